// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types and constants for the ALU operand sequencer: FSM state encoding,
// opcode values and the active-low 7-segment hex decoder.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      S_LOAD_A  = 3'd0,
      S_LOAD_B  = 3'd1,
      S_LOAD_OP = 3'd2,
      S_EXEC    = 3'd3,
      S_CAPTURE = 3'd4,
      S_SHOW    = 3'd5
   } state_t;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_SHL = 4'd3;
   localparam logic [3:0] OP_SHR = 4'd4;
   localparam logic [3:0] OP_MAX = 4'd4;

   // Segment order is gfedcba; a 0 bit lights the segment.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         4'hF:    seg = 7'b0001110;
         default: seg = 7'b0111111;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce counter and a one-cycle
// press pulse on an accepted rising level.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q,   sync_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             stable_q, stable_d;
   logic             armed_q,  armed_d;
   logic             press_q,  press_d;

   // Sync flops reset high so a button held across reset cannot count as a press;
   // armed only sets once a released level is seen after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= 2'b11;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         armed_q  <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         armed_q  <= armed_d;
         press_q  <= press_d;
      end
   end

   always_comb begin
      sync_d   = {sync_q[0], btn_i};
      cnt_d    = cnt_q;
      stable_d = stable_q;
      armed_d  = armed_q;
      press_d  = 1'b0;
      if (sync_q[1] == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d    = '0;
         stable_d = sync_q[1];
         press_d  = sync_q[1] & armed_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (!sync_q[1] && !stable_q) begin
         armed_d = 1'b1;
      end else begin
         armed_d = armed_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Board-side controller for the lab ALU: loads A, B and opcode on successive
// debounced presses, then captures and holds the ALU result for display.
module alu_operand_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] sw,
   input  logic [3:0]   op_sw,
   input  logic         btn_next,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_op,
   input  logic [N-1:0] alu_y,
   output logic [N-1:0] result,
   output logic         result_vld,
   output logic         done,
   output logic         op_err,
   output logic [2:0]   state_code,
   output logic [6:0]   seg
);

   logic press_s;
   logic [3:0] nib_s;

   state_t       state_q,  state_d;
   logic [N-1:0] a_q,      a_d;
   logic [N-1:0] b_q,      b_d;
   logic [3:0]   op_q,     op_d;
   logic [N-1:0] res_q,    res_d;
   logic         vld_q,    vld_d;
   logic         done_q,   done_d;
   logic         err_q,    err_d;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_next),
      .press_o(press_s)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 4'd0;
         res_q   <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // done and result_vld are registered alongside the state they describe.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         S_LOAD_A: begin
            if (press_s) begin
               a_d     = sw;
               state_d = S_LOAD_B;
            end else begin
               state_d = S_LOAD_A;
            end
         end
         S_LOAD_B: begin
            if (press_s) begin
               b_d     = sw;
               state_d = S_LOAD_OP;
            end else begin
               state_d = S_LOAD_B;
            end
         end
         S_LOAD_OP: begin
            if (press_s) begin
               op_d    = op_sw;
               state_d = S_EXEC;
            end else begin
               state_d = S_LOAD_OP;
            end
         end
         S_EXEC: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            res_d   = alu_y;
            err_d   = (op_q > OP_MAX);
            done_d  = 1'b1;
            state_d = S_SHOW;
         end
         S_SHOW: begin
            if (press_s) begin
               state_d = S_LOAD_A;
            end else begin
               state_d = S_SHOW;
            end
         end
         default: begin
            state_d = S_LOAD_A;
         end
      endcase
      vld_d = (state_d == S_SHOW);
   end

   if (N >= 4) begin : g_nib_full
      assign nib_s = res_q[3:0];
   end else begin : g_nib_ext
      assign nib_s = {{(4-N){1'b0}}, res_q};
   end

   assign seg        = hex_to_seg(nib_s);
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign result     = res_q;
   assign result_vld = vld_q;
   assign done       = done_q;
   assign op_err     = err_q;
   assign state_code = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a behavioural ALU stand-in
// and an arithmetic reference model of the expected results.
module tb_alu_operand_sequencer;

   localparam int N  = 4;
   localparam int DC = 4;
   localparam logic [6:0] SEG_TAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] sw = '0;
   logic [3:0]   op_sw = 4'd0;
   logic         btn_next = 1'b0;
   logic [N-1:0] alu_a, alu_b, alu_y, result;
   logic [3:0]   alu_op;
   logic         result_vld, done, op_err;
   logic [2:0]   state_code;
   logic [6:0]   seg;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   bit in_show = 1'b0;
   int last_err = 0;

   alu_operand_sequencer #(.N(N), .DEBOUNCE_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw), .btn_next(btn_next),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
      .result(result), .result_vld(result_vld), .done(done), .op_err(op_err),
      .state_code(state_code), .seg(seg)
   );

   always #5 clk = ~clk;

   // Lab ALU stand-in driven by the registered operands.
   always_comb begin
      case (alu_op)
         4'd0:    alu_y = alu_a & alu_b;
         4'd1:    alu_y = alu_a | alu_b;
         4'd2:    alu_y = alu_a ^ alu_b;
         4'd3:    alu_y = alu_a << alu_b;
         4'd4:    alu_y = alu_a >> alu_b;
         default: alu_y = '0;
      endcase
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   function automatic int ref_alu(int a, int b, int op);
      case (op)
         0:       return a & b;
         1:       return a | b;
         2:       return a ^ b;
         3:       return (a * (2 ** b)) % 16;
         4:       return a / (2 ** b);
         default: return 0;
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(int hi, int lo);
      btn_next = 1'b1;
      repeat (hi) @(negedge clk);
      btn_next = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic press();
      pulse(10, 12);
   endtask

   task automatic run_op(int a, int b, int op);
      int d0;
      int exp_y;
      if (in_show) begin
         press();
         check("ret_state", 32'(state_code), 32'd0);
         check("ret_vld", 32'(result_vld), 32'd0);
         check("err_held", 32'(op_err), 32'(last_err));
      end
      sw = N'(a);
      press();
      check("state_b", 32'(state_code), 32'd1);
      check("alu_a", 32'(alu_a), 32'(a));
      sw = N'(b);
      press();
      check("state_op", 32'(state_code), 32'd2);
      check("alu_b", 32'(alu_b), 32'(b));
      op_sw = 4'(op);
      d0 = done_cnt;
      press();
      exp_y = ref_alu(a, b, op);
      check("state_show", 32'(state_code), 32'd5);
      check("vld", 32'(result_vld), 32'd1);
      check("alu_op", 32'(alu_op), 32'(op));
      check("result", 32'(result), 32'(exp_y));
      check("op_err", 32'(op_err), (op > 4) ? 32'd1 : 32'd0);
      check("seg", 32'(seg), 32'(SEG_TAB[exp_y]));
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("done_low", 32'(done), 32'd0);
      last_err = (op > 4) ? 1 : 0;
      in_show = 1'b1;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_state", 32'(state_code), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_vld", 32'(result_vld), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(op_err), 32'd0);
      check("rst_seg", 32'(seg), 32'b1000000);

      // Logic ops and shifts
      run_op(12, 10, 0);
      check("and_seg8", 32'(seg), 32'b0000000);
      run_op(12, 10, 1);
      check("or_val", 32'(result), 32'hE);
      run_op(12, 10, 2);
      check("xor_val", 32'(result), 32'h6);
      run_op(3, 2, 3);
      check("shl_val", 32'(result), 32'hC);
      run_op(8, 3, 4);
      check("shr_val", 32'(result), 32'h1);

      // Illegal opcode, then return to LOAD_A with op_err held
      run_op(7, 5, 9);
      press();
      in_show = 1'b0;
      check("bad_ret_state", 32'(state_code), 32'd0);
      check("bad_err_held", 32'(op_err), 32'd1);
      check("bad_res_held", 32'(result), 32'd0);

      // Glitches shorter than the debounce window never advance
      sw = 4'h6;
      pulse(1, 3);
      pulse(2, 3);
      pulse(3, 3);
      repeat (10) @(negedge clk);
      check("glitch_state", 32'(state_code), 32'd0);
      pulse(1, 1);
      pulse(2, 1);
      pulse(1, 1);
      press();
      check("bounce_state", 32'(state_code), 32'd1);
      check("bounce_a", 32'(alu_a), 32'h6);
      sw = 4'h3;
      pulse(100, 12);
      check("hold_state", 32'(state_code), 32'd2);
      op_sw = 4'd1;
      press();
      check("hold_result", 32'(result), 32'h7);
      in_show = 1'b1;
      last_err = 0;

      // Randomised operations against the reference model
      for (int i = 0; i < 12; i++) begin
         run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)));
      end

      // Reset in LOAD_OP with the button held
      run_op(5, 9, 1);
      press();
      sw = 4'h5;
      press();
      sw = 4'h9;
      press();
      check("pre_rst_state", 32'(state_code), 32'd2);
      btn_next = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_state", 32'(state_code), 32'd0);
      check("mid_rst_a", 32'(alu_a), 32'd0);
      check("mid_rst_b", 32'(alu_b), 32'd0);
      check("mid_rst_op", 32'(alu_op), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("held_after_rst", 32'(state_code), 32'd0);
      btn_next = 1'b0;
      repeat (12) @(negedge clk);
      check("released_after_rst", 32'(state_code), 32'd0);
      sw = 4'hB;
      press();
      check("repress_state", 32'(state_code), 32'd1);
      check("repress_a", 32'(alu_a), 32'hB);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
